// File: rtl/vscale_wb_ctrl_pkg.sv
// Shared constants for the write-back controller: register/data widths and FSM encodings.
package vscale_wb_ctrl_pkg;

  localparam int REG_ADDR_WIDTH      = 5;
  localparam int XPR_LEN             = 32;
  localparam int WB_CTRL_STATE_WIDTH = 2;

  typedef enum logic [WB_CTRL_STATE_WIDTH-1:0] {
    WB_CTRL_IDLE  = 2'd0,
    WB_CTRL_HOLD  = 2'd1,
    WB_CTRL_FORCE = 2'd2
  } wb_ctrl_state_e;

endpackage

// File: rtl/vscale_tag_fifo.sv
// Synchronous FIFO of MD destination register addresses; same-cycle push+pop on full pops first.
module vscale_tag_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           rd_ptr, wr_ptr;
  logic [PW:0]             count;
  logic                    do_push, do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vscale_wb_ctrl.sv
// Regfile write-port arbiter between pipeline write-back and out-of-order MD responses.
// Optional starvation guard (counter, FORCE state, pipe_stall) under VSCALE_WB_STARVE_GUARD_EN.
module vscale_wb_ctrl
  import vscale_wb_ctrl_pkg::*;
#(
  parameter int Q_DEPTH      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      wb_valid,
  input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
  input  logic [XPR_LEN-1:0]        wb_data,
  input  logic                      md_issue,
  input  logic [REG_ADDR_WIDTH-1:0] md_issue_rd,
  output logic                      md_issue_ready,
  input  logic                      md_resp_valid,
  input  logic [XPR_LEN-1:0]        md_resp_data,
  output logic                      md_resp_ready,
  input  logic [REG_ADDR_WIDTH-1:0] dec_ra1,
  input  logic [REG_ADDR_WIDTH-1:0] dec_ra2,
  input  logic [REG_ADDR_WIDTH-1:0] dec_rd,
  input  logic                      dec_wen,
  output logic                      stall_hazard,
  output logic                      pipe_stall,
  output logic                      rf_wen,
  output logic [REG_ADDR_WIDTH-1:0] rf_wa,
  output logic [XPR_LEN-1:0]        rf_wd,
  output logic                      bypass_rs1,
  output logic                      bypass_rs2,
  output logic [XPR_LEN-1:0]        bypass_data
);

  localparam int NREG = 2 ** REG_ADDR_WIDTH;

  if (Q_DEPTH < 2 || (Q_DEPTH & (Q_DEPTH - 1)) != 0) begin : g_bad_q_depth
    $error("vscale_wb_ctrl: Q_DEPTH must be a power of two >= 2");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
    $error("vscale_wb_ctrl: STARVE_LIMIT must be >= 1");
  end

  wb_ctrl_state_e            state, state_nxt;
  logic                      fifo_full, fifo_empty;
  logic [REG_ADDR_WIDTH-1:0] fifo_head;
  logic                      issue_push, resp_acc, capture;
  logic [REG_ADDR_WIDTH-1:0] buf_rd;
  logic [XPR_LEN-1:0]        buf_data;
  logic [NREG-1:0]           pending;
  logic                      wr_vld;
  logic [REG_ADDR_WIDTH-1:0] wr_addr;
  logic [XPR_LEN-1:0]        wr_data;

  assign md_issue_ready = !fifo_full;
  assign issue_push     = md_issue && md_issue_ready;
  assign md_resp_ready  = (state == WB_CTRL_IDLE) && !fifo_empty;
  assign resp_acc       = md_resp_valid && md_resp_ready;
  // Results for x0 are simply dropped rather than parked in the buffer.
  assign capture        = resp_acc && wb_valid && (fifo_head != '0);

  vscale_tag_fifo #(.DEPTH(Q_DEPTH), .W(REG_ADDR_WIDTH)) u_tag_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (issue_push),
    .pop    (resp_acc),
    .din    (md_issue_rd),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (fifo_head)
  );

`ifdef VSCALE_WB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT) + 1;
  logic [CNT_W-1:0] starve_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                               starve_cnt <= '0;
    else if (state == WB_CTRL_HOLD && state_nxt == WB_CTRL_HOLD) starve_cnt <= starve_cnt + 1'b1;
    else                                                        starve_cnt <= '0;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= WB_CTRL_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WB_CTRL_IDLE: if (capture) state_nxt = WB_CTRL_HOLD;
      WB_CTRL_HOLD: begin
        if (!wb_valid) state_nxt = WB_CTRL_IDLE;
`ifdef VSCALE_WB_STARVE_GUARD_EN
        else if (starve_cnt == CNT_W'(STARVE_LIMIT - 1)) state_nxt = WB_CTRL_FORCE;
`endif
      end
`ifdef VSCALE_WB_STARVE_GUARD_EN
      WB_CTRL_FORCE: if (!wb_valid) state_nxt = WB_CTRL_IDLE;
`endif
      default: state_nxt = WB_CTRL_IDLE;
    endcase
  end

  // Pipeline write-back always owns the port; a parked result drains before new responses.
  always_comb begin
    wr_vld  = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (wb_valid) begin
      wr_vld  = 1'b1;
      wr_addr = wb_addr;
      wr_data = wb_data;
    end else if (state != WB_CTRL_IDLE) begin
      wr_vld  = 1'b1;
      wr_addr = buf_rd;
      wr_data = buf_data;
    end else if (resp_acc) begin
      wr_vld  = 1'b1;
      wr_addr = fifo_head;
      wr_data = md_resp_data;
    end
    rf_wen = wr_vld && (wr_addr != '0);
    rf_wa  = rf_wen ? wr_addr : '0;
    rf_wd  = rf_wen ? wr_data : '0;
`ifdef VSCALE_WB_STARVE_GUARD_EN
    pipe_stall = (state == WB_CTRL_FORCE);
`else
    pipe_stall = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_rd   <= '0;
      buf_data <= '0;
    end else if (capture) begin
      buf_rd   <= fifo_head;
      buf_data <= md_resp_data;
    end
  end

  // Bit 0 stays clear so x0 never reads as pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
    end else begin
      pending[0] <= 1'b0;
      for (int i = 1; i < NREG; i++) begin
        if (issue_push && md_issue_rd == REG_ADDR_WIDTH'(i))
          pending[i] <= 1'b1;
        else if (rf_wen && rf_wa == REG_ADDR_WIDTH'(i))
          pending[i] <= 1'b0;
      end
    end
  end

  assign bypass_rs1  = rf_wen && (rf_wa == dec_ra1) && (dec_ra1 != '0);
  assign bypass_rs2  = rf_wen && (rf_wa == dec_ra2) && (dec_ra2 != '0);
  assign bypass_data = rf_wd;

  assign stall_hazard = (pending[dec_ra1] && !(rf_wen && rf_wa == dec_ra1)) ||
                        (pending[dec_ra2] && !(rf_wen && rf_wa == dec_ra2)) ||
                        (dec_wen && pending[dec_rd] && !(rf_wen && rf_wa == dec_rd));

endmodule

// File: tb/tb_vscale_wb_ctrl.sv
// Directed plus randomized bench for vscale_wb_ctrl against a queue-based reference model.
module tb_vscale_wb_ctrl;
  localparam int QD = 2;
  localparam int SL = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wb_valid, md_issue, md_resp_valid, dec_wen;
  logic [4:0]  wb_addr, md_issue_rd, dec_ra1, dec_ra2, dec_rd;
  logic [31:0] wb_data, md_resp_data;
  logic        md_issue_ready, md_resp_ready, stall_hazard, pipe_stall;
  logic        rf_wen, bypass_rs1, bypass_rs2;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd, bypass_data;

  always #5 clk = ~clk;

  vscale_wb_ctrl #(.Q_DEPTH(QD), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset_n(reset_n),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .md_issue(md_issue), .md_issue_rd(md_issue_rd), .md_issue_ready(md_issue_ready),
    .md_resp_valid(md_resp_valid), .md_resp_data(md_resp_data), .md_resp_ready(md_resp_ready),
    .dec_ra1(dec_ra1), .dec_ra2(dec_ra2), .dec_rd(dec_rd), .dec_wen(dec_wen),
    .stall_hazard(stall_hazard), .pipe_stall(pipe_stall),
    .rf_wen(rf_wen), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .bypass_rs1(bypass_rs1), .bypass_rs2(bypass_rs2), .bypass_data(bypass_data)
  );

  int n_pass = 0, n_fail = 0, n_total = 0;

  // Reference model: set of pending registers, ordered list of outstanding rds, parked result.
  bit [31:0]   m_pend;
  int          m_q[$];
  bit          m_buf_full, m_forced, m_acc;
  logic [4:0]  m_buf_rd;
  logic [31:0] m_buf_data;
  int          m_holds;
  logic        e_iready, e_rready, e_wen, e_by1, e_by2, e_haz, e_pstall;
  logic [4:0]  e_wa;
  logic [31:0] e_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic bit blocked(input logic [4:0] r);
    return (r != 0) && m_pend[r] && !(e_wen && e_wa == r);
  endfunction

  task automatic model_eval();
    logic       v;
    logic [4:0] a;
    logic [31:0] d;
    e_iready = (m_q.size() < QD);
    e_rready = !m_buf_full && (m_q.size() > 0);
    m_acc    = md_resp_valid && e_rready;
    v = 0; a = 0; d = 0;
    if (wb_valid)        begin v = 1; a = wb_addr;  d = wb_data; end
    else if (m_buf_full) begin v = 1; a = m_buf_rd; d = m_buf_data; end
    else if (m_acc)      begin v = 1; a = 5'(m_q[0]); d = md_resp_data; end
    e_wen    = v && (a != 0);
    e_wa     = e_wen ? a : 5'd0;
    e_wd     = e_wen ? d : 32'd0;
    e_by1    = e_wen && e_wa == dec_ra1 && dec_ra1 != 0;
    e_by2    = e_wen && e_wa == dec_ra2 && dec_ra2 != 0;
    e_haz    = blocked(dec_ra1) || blocked(dec_ra2) || (dec_wen && blocked(dec_rd));
    e_pstall = m_forced;
  endtask

  task automatic model_step();
    logic [4:0] head;
    head = (m_q.size() > 0) ? 5'(m_q[0]) : 5'd0;
    if (e_wen) m_pend[e_wa] = 1'b0;
    if (md_issue && e_iready && md_issue_rd != 0) m_pend[md_issue_rd] = 1'b1;
    if (m_buf_full) begin
      if (!wb_valid) begin m_buf_full = 0; m_forced = 0; end
      else begin
        m_holds++;
`ifdef VSCALE_WB_STARVE_GUARD_EN
        if (m_holds >= SL) m_forced = 1;
`endif
      end
    end else if (m_acc && wb_valid && head != 0) begin
      m_buf_full = 1; m_buf_rd = head; m_buf_data = md_resp_data; m_holds = 0;
    end
    if (m_acc) void'(m_q.pop_front());
    if (md_issue && e_iready) m_q.push_back(int'(md_issue_rd));
  endtask

  task automatic check_all(input string pfx);
    model_eval();
    chk({pfx, "_iready"}, 32'(md_issue_ready), 32'(e_iready));
    chk({pfx, "_rready"}, 32'(md_resp_ready), 32'(e_rready));
    chk({pfx, "_wen"},    32'(rf_wen), 32'(e_wen));
    chk({pfx, "_wa"},     32'(rf_wa), 32'(e_wa));
    chk({pfx, "_wd"},     rf_wd, e_wd);
    chk({pfx, "_by1"},    32'(bypass_rs1), 32'(e_by1));
    chk({pfx, "_by2"},    32'(bypass_rs2), 32'(e_by2));
    chk({pfx, "_bydata"}, bypass_data, e_wd);
    chk({pfx, "_haz"},    32'(stall_hazard), 32'(e_haz));
    chk({pfx, "_pstall"}, 32'(pipe_stall), 32'(e_pstall));
  endtask

  task automatic step(input string pfx);
    #1;
    check_all(pfx);
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic clr_in();
    wb_valid = 0; wb_addr = 0; wb_data = 0;
    md_issue = 0; md_issue_rd = 0; md_resp_valid = 0; md_resp_data = 0;
    dec_ra1 = 0; dec_ra2 = 0; dec_rd = 0; dec_wen = 0;
  endtask

  task automatic do_reset(input string pfx);
    clr_in();
    reset_n = 0;
    m_pend = 0; m_q.delete(); m_buf_full = 0; m_forced = 0; m_holds = 0;
    m_buf_rd = 0; m_buf_data = 0;
    #1;
    check_all(pfx);
    @(negedge clk);
    reset_n = 1;
  endtask

  initial begin
    clr_in();
    do_reset("rst");

    // Direct write of an MD result with bypass to decode.
    md_issue = 1; md_issue_rd = 5; step("iss5");
    clr_in(); step("w1"); step("w2");
    md_resp_valid = 1; md_resp_data = 32'h1234; dec_ra1 = 5;
    #1;
    chk("direct_wen", 32'(rf_wen), 32'd1);
    chk("direct_wa", 32'(rf_wa), 32'd5);
    chk("direct_wd", rf_wd, 32'h1234);
    chk("direct_by1", 32'(bypass_rs1), 32'd1);
    step("resp5");
    clr_in(); dec_ra1 = 5;
    #1 chk("pend5_clear", 32'(stall_hazard), 32'd0);
    step("after5");

    // Hazard on rs2 until the write cycle.
    clr_in(); md_issue = 1; md_issue_rd = 7; step("iss7");
    clr_in(); dec_ra2 = 7;
    #1 chk("haz7", 32'(stall_hazard), 32'd1);
    step("haz7s");
    md_resp_valid = 1; md_resp_data = 32'hBEEF_0007;
    #1;
    chk("wr7_by2", 32'(bypass_rs2), 32'd1);
    chk("wr7_haz", 32'(stall_hazard), 32'd0);
    step("wr7");

    // Response collides with pipeline write-back: buffered then drained.
    clr_in(); md_issue = 1; md_issue_rd = 10; step("iss10");
    clr_in(); md_issue = 1; md_issue_rd = 11;
    md_resp_valid = 1; md_resp_data = 32'hAAAA_000A;
    wb_valid = 1; wb_addr = 3; wb_data = 32'h3333;
    #1 chk("coll_wa", 32'(rf_wa), 32'd3);
    step("coll");
    clr_in(); wb_valid = 1; wb_addr = 4; wb_data = 32'h4444; md_resp_valid = 1; dec_ra1 = 10;
    #1;
    chk("hold_rready", 32'(md_resp_ready), 32'd0);
    chk("hold_haz10", 32'(stall_hazard), 32'd1);
    step("hold1");
    wb_valid = 0;
    #1;
    chk("drain_wa", 32'(rf_wa), 32'd10);
    chk("drain_wd", rf_wd, 32'hAAAA_000A);
    chk("drain_by1", 32'(bypass_rs1), 32'd1);
    step("drain");
    clr_in(); md_resp_valid = 1; md_resp_data = 32'h0B0B; step("resp11");

    // Starvation: write-back held high while a result is parked.
    clr_in(); md_issue = 1; md_issue_rd = 12; step("iss12");
    clr_in(); md_resp_valid = 1; md_resp_data = 32'hC0C0; wb_valid = 1; wb_addr = 2; step("cap12");
    clr_in();
    for (int i = 0; i < SL; i++) begin
      wb_valid = 1; wb_addr = 6; wb_data = 32'(i);
      step("starve");
    end
    wb_valid = 0;
    #1;
`ifdef VSCALE_WB_STARVE_GUARD_EN
    chk("force_pstall", 32'(pipe_stall), 32'd1);
`else
    chk("noguard_pstall", 32'(pipe_stall), 32'd0);
`endif
    chk("force_wa", 32'(rf_wa), 32'd12);
    step("force_drain");
    clr_in(); #1 chk("force_idle_pstall", 32'(pipe_stall), 32'd0);
    step("post_force");

    // Full FIFO: third issue dropped, responses in order.
    md_issue = 1; md_issue_rd = 8; step("iss8");
    md_issue_rd = 9; step("iss9");
    md_issue_rd = 13;
    #1 chk("full_iready", 32'(md_issue_ready), 32'd0);
    step("iss13");
    clr_in(); dec_ra1 = 13;
    #1 chk("dropped13", 32'(stall_hazard), 32'd0);
    md_resp_valid = 1; md_resp_data = 32'h88;
    #1 chk("ord_wa8", 32'(rf_wa), 32'd8);
    step("resp8");
    md_resp_data = 32'h99;
    #1 chk("ord_wa9", 32'(rf_wa), 32'd9);
    step("resp9");
    #1 chk("empty_rready", 32'(md_resp_ready), 32'd0);
    step("resp_empty");

    // Reset while holding a parked result with two pending registers.
    clr_in(); md_issue = 1; md_issue_rd = 14; step("iss14");
    md_issue_rd = 15; md_resp_valid = 1; md_resp_data = 32'hE; wb_valid = 1; wb_addr = 1;
    step("cap14");
    clr_in(); wb_valid = 1; wb_addr = 1; step("hold14");
    do_reset("midrst");
    dec_ra1 = 14; dec_ra2 = 15;
    #1 chk("rst_sb_clear", 32'(stall_hazard), 32'd0);
    step("post_rst");

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      md_issue      = ($urandom_range(0, 2) == 0);
      md_issue_rd   = 5'($urandom_range(0, 7));
      md_resp_valid = ($urandom_range(0, 1) == 1);
      md_resp_data  = $urandom;
      wb_valid      = m_forced ? 1'b0 : ($urandom_range(0, 1) == 1);
      wb_addr       = 5'($urandom_range(0, 7));
      wb_data       = $urandom;
      dec_ra1       = 5'($urandom_range(0, 7));
      dec_ra2       = 5'($urandom_range(0, 7));
      dec_rd        = 5'($urandom_range(0, 7));
      dec_wen       = ($urandom_range(0, 1) == 1);
      step("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
